// File: rtl/shift_sub_divider.sv
// Sequential 16/8 restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Divide-by-zero and quotient overflow are detected up front and answered in a single cycle.
module shift_sub_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        overflow
);

  localparam int unsigned STAGES = 8;
  localparam logic [2:0]  LAST   = 3'(STAGES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic [2:0] count;
  logic [7:0] pr;
  logic [7:0] sr;
  logic [7:0] dvsr;
  logic [8:0] step;
  logic       accept;

  // One restoring step: returns {quotient bit, new partial remainder}.
  // The overflow pre-check keeps the partial remainder below the divisor,
  // so bit 8 of the restored value is always zero and is not stored.
  function automatic logic [8:0] restore_step(input logic [8:0] shifted,
                                              input logic [7:0] d);
    logic signed [9:0] trial;
    trial = $signed({1'b0, shifted}) - $signed({2'b00, d});
    if (trial >= 0)
      return {1'b1, trial[7:0]};
    else
      return {1'b0, shifted[7:0]};
  endfunction

  always_comb begin
    step   = restore_step({pr, sr[7]}, dvsr);
    accept = (state == IDLE) && start && (divisor != 8'd0) &&
             (dividend[15:8] < divisor);
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 3'd0;
      quotient  <= 8'd0;
      remainder <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == 8'd0) begin
              div_zero  <= 1'b1;
              overflow  <= 1'b0;
              quotient  <= 8'hFF;
              remainder <= 8'hFF;
              done      <= 1'b1;
              state     <= DONE;
            end else if (dividend[15:8] >= divisor) begin
              div_zero  <= 1'b0;
              overflow  <= 1'b1;
              quotient  <= 8'hFF;
              remainder <= 8'hFF;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              div_zero <= 1'b0;
              overflow <= 1'b0;
              busy     <= 1'b1;
              count    <= 3'd0;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          count <= count + 3'd1;
          if (count == LAST) begin
            quotient  <= {sr[6:0], step[8]};
            remainder <= step[7:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Iteration datapath: loaded on an accepted start, shifted every CALC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      dvsr <= divisor;
      pr   <= dividend[15:8];
      sr   <= dividend[7:0];
    end else if (state == CALC) begin
      pr <= step[7:0];
      sr <= {sr[6:0], step[8]};
    end
  end

endmodule
